alarm_annunciator: RTL and testbench

- Downstream consumer of the alarm state register (state_change).
- Replaces the purely combinational LED mapping with timed, registered indication:
  - armed-blip pattern while armed
  - flashing alarm LED plus buzzer while in alarm
  - auto-silence timeout and a manual acknowledge
- Time base is the tick_lf pulse from freq_divider; the ack input comes from an anti_bounce instance.

---
 rtl/alarm_pkg.sv | 21 ++
 rtl/tick_counter.sv | 48 ++++
 rtl/alarm_annunciator.sv | 130 +++++++++++++
 tb/tb_alarm_annunciator.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: encodings shared between the alarm state register (state_change)
// and its downstream annunciator.
//   alarm_state_e : 2-bit alarm state carried on the 'state' bus
//   ann_state_e   : internal annunciator FSM states
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_ALARM    = 2'b10,
        ST_RSVD     = 2'b11
    } alarm_state_e;

    typedef enum logic [1:0] {
        AnnOff      = 2'b00,
        AnnArmInd   = 2'b01,
        AnnSounding = 2'b10,
        AnnSilenced = 2'b11
    } ann_state_e;

endpackage

// File: rtl/tick_counter.sv
// tick_counter: tick-enabled counter with clear and terminal-count flag.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : force count to zero (wins over tick_i)
//   tick_i       : advance by one
//   wrap_i       : at terminal count, 1 = wrap to zero, 0 = saturate
//   term_i       : terminal count value
//   next_o       : count value that will be loaded on the next edge
//   tc_o         : current count has reached term_i
module tick_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             tick_i,
    input  logic             wrap_i,
    input  logic [Width-1:0] term_i,
    output logic [Width-1:0] next_o,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        // >= keeps the counter bounded even if term_i drops below the count
        tc_o  = (cnt_q >= term_i);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (tc_o) begin
                cnt_d = wrap_i ? '0 : cnt_q;
            end else begin
                cnt_d = cnt_q + Width'(1);
            end
        end
        next_o = cnt_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alarm_annunciator.sv
// alarm_annunciator: timed, registered LED/buzzer indication for the alarm state.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   tick_lf   : one-cycle low-frequency time-base pulse
//   state     : alarm state (00 disarmed, 01 armed, 10 alarm, 11 treated as alarm)
//   ack       : debounced acknowledge level, rising edge silences the buzzer
//   armed_led : armed blip while armed, steady on during alarm
//   alarm_led : flashing while sounding, steady once silenced
//   buzzer    : follows alarm_led while sounding, off once silenced
module alarm_annunciator
    import alarm_pkg::*;
#(
    parameter int unsigned ARM_PERIOD    = 8,
    parameter int unsigned ALARM_TIMEOUT = 60,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_lf,
    input  logic [1:0] state,
    input  logic       ack,
    output logic       armed_led,
    output logic       alarm_led,
    output logic       buzzer
);

    if (ARM_PERIOD < 2 || ARM_PERIOD > (2 ** CNT_W) - 1) begin : g_bad_arm_period
        $error("alarm_annunciator: ARM_PERIOD out of range");
    end
    if (ALARM_TIMEOUT < 1 || ALARM_TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_timeout
        $error("alarm_annunciator: ALARM_TIMEOUT out of range");
    end

    localparam logic [CNT_W-1:0] ArmTerm     = CNT_W'(ARM_PERIOD - 1);
    localparam logic [CNT_W-1:0] TimeoutTerm = CNT_W'(ALARM_TIMEOUT - 1);

    ann_state_e       fsm_q, fsm_d;
    logic             ack_q, ack_rise;
    logic             entry;
    // Flash phase: 0 = lamp-on half, so clearing it on entry starts the flash lit.
    logic             phase_q, phase_d;
    logic             cnt_tick, cnt_wrap, cnt_tc;
    logic [CNT_W-1:0] cnt_term, cnt_next;
    logic             armed_led_d, alarm_led_d, buzzer_d;

    tick_counter #(
        .Width (CNT_W)
    ) u_tick_counter (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (entry),
        .tick_i (cnt_tick),
        .wrap_i (cnt_wrap),
        .term_i (cnt_term),
        .next_o (cnt_next),
        .tc_o   (cnt_tc)
    );

    // Next FSM state
    always_comb begin
        ack_rise = ack & ~ack_q;
        fsm_d    = fsm_q;
        case (alarm_state_e'(state))
            ST_DISARMED: fsm_d = AnnOff;
            ST_ARMED:    fsm_d = AnnArmInd;
            default: begin
                // ST_ALARM and ST_RSVD both alarm; SILENCED holds until state leaves.
                if (fsm_q == AnnSounding) begin
                    if ((tick_lf && cnt_tc) || ack_rise) begin
                        fsm_d = AnnSilenced;
                    end
                end else if (fsm_q != AnnSilenced) begin
                    fsm_d = AnnSounding;
                end
            end
        endcase
    end

    // Counter control, flash phase and next outputs
    always_comb begin
        entry    = (fsm_d != fsm_q);
        // A state change in a tick cycle wins; that tick is dropped via clr.
        cnt_tick = tick_lf && (fsm_q == AnnArmInd || fsm_q == AnnSounding);
        cnt_wrap = (fsm_q == AnnArmInd);
        cnt_term = (fsm_q == AnnArmInd) ? ArmTerm : TimeoutTerm;

        phase_d = phase_q;
        if (entry) begin
            phase_d = 1'b0;
        end else if (fsm_q == AnnSounding && tick_lf) begin
            phase_d = ~phase_q;
        end

        armed_led_d = 1'b0;
        alarm_led_d = 1'b0;
        buzzer_d    = 1'b0;
        unique case (fsm_d)
            AnnOff: ;
            AnnArmInd: armed_led_d = (cnt_next == '0);
            AnnSounding: begin
                armed_led_d = 1'b1;
                alarm_led_d = ~phase_d;
                buzzer_d    = ~phase_d;
            end
            AnnSilenced: begin
                armed_led_d = 1'b1;
                alarm_led_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= AnnOff;
            phase_q   <= 1'b0;
            ack_q     <= 1'b0;
            armed_led <= 1'b0;
            alarm_led <= 1'b0;
            buzzer    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            phase_q   <= phase_d;
            ack_q     <= ack;
            armed_led <= armed_led_d;
            alarm_led <= alarm_led_d;
            buzzer    <= buzzer_d;
        end
    end

endmodule

// File: tb/tb_alarm_annunciator.sv
module tb_alarm_annunciator;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_lf;
    logic [1:0] state;
    logic       ack;
    logic       armed_led, alarm_led, buzzer;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {armed, alarm, buzzer} after each of the 4 timeout ticks (TIMEOUT=4)
    logic [2:0] snd_seq [4];

    always #5 clk = ~clk;

    alarm_annunciator #(
        .ARM_PERIOD    (8),
        .ALARM_TIMEOUT (4),
        .CNT_W         (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_lf   (tick_lf),
        .state     (state),
        .ack       (ack),
        .armed_led (armed_led),
        .alarm_led (alarm_led),
        .buzzer    (buzzer)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock with optional tick, then compare {armed, alarm, buzzer}.
    task automatic cyc(input logic tk, input logic [2:0] exp, input string tag);
        tick_lf = tk;
        @(posedge clk);
        #1;
        tick_lf = 1'b0;
        check(tag, {29'd0, armed_led, alarm_led, buzzer}, {29'd0, exp});
    endtask

    task automatic run_timeout(input string tag);
        for (int i = 0; i < 4; i++) cyc(1'b1, snd_seq[i], tag);
    endtask

    initial begin
        snd_seq[0] = 3'b100;
        snd_seq[1] = 3'b111;
        snd_seq[2] = 3'b100;
        snd_seq[3] = 3'b110;

        rst = 1'b1; state = 2'b01; tick_lf = 1'b0; ack = 1'b0;
        cyc(1'b0, 3'b000, "rst_c1");
        cyc(1'b1, 3'b000, "rst_c2");
        rst = 1'b0;
        cyc(1'b0, 3'b100, "rst_release");

        // Armed blip: on at tick counts 0, 8, 16
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, {(i % 8 == 0), 2'b00}, "blip_tick");
            cyc(1'b0, {(i % 8 == 0), 2'b00}, "blip_hold");
        end
        ack = 1'b1;
        cyc(1'b0, 3'b000, "ack_in_armed");
        ack = 1'b0;

        // Alarm timeout
        state = 2'b10;
        cyc(1'b0, 3'b111, "snd_entry");
        run_timeout("timeout");
        cyc(1'b1, 3'b110, "sil_tick");
        ack = 1'b1;
        cyc(1'b0, 3'b110, "sil_ack");
        ack = 1'b0;
        state = 2'b11;
        cyc(1'b1, 3'b110, "sil_rsvd");

        // State change coinciding with a tick: change wins
        state = 2'b00;
        cyc(1'b1, 3'b000, "exit_with_tick");
        state = 2'b01;
        cyc(1'b1, 3'b100, "arm_entry_tick");
        cyc(1'b1, 3'b000, "arm_tick1");
        state = 2'b10;
        cyc(1'b1, 3'b111, "snd_entry_tick");
        run_timeout("timeout2");

        state = 2'b00;
        cyc(1'b0, 3'b000, "off_a");
        state = 2'b10;
        cyc(1'b0, 3'b111, "snd_entry_b");
        cyc(1'b1, 3'b100, "snd_t1_b");
        state = 2'b00;
        cyc(1'b1, 3'b000, "chg_tick");
        state = 2'b10;
        cyc(1'b0, 3'b111, "reentry");
        run_timeout("timeout3");

        // Ack silence, held ack
        state = 2'b00;
        cyc(1'b0, 3'b000, "off_c");
        state = 2'b10;
        cyc(1'b0, 3'b111, "snd_entry_c");
        cyc(1'b1, 3'b100, "ack_pre");
        ack = 1'b1;
        cyc(1'b0, 3'b110, "ack_sil");
        for (int i = 0; i < 50; i++) cyc(i % 7 == 3, 3'b110, "ack_hold");
        state = 2'b00;
        cyc(1'b0, 3'b000, "ack_exit");
        state = 2'b10;
        cyc(1'b0, 3'b111, "held_ack_entry");
        cyc(1'b1, 3'b100, "held_ack_t1");
        ack = 1'b0;
        cyc(1'b0, 3'b100, "ack_low");
        ack = 1'b1;
        cyc(1'b0, 3'b110, "ack_edge2");
        ack = 1'b0;

        // Timeout tick and ack edge together
        state = 2'b00;
        cyc(1'b0, 3'b000, "off_d");
        state = 2'b10;
        cyc(1'b0, 3'b111, "snd_entry_d");
        cyc(1'b1, 3'b100, "snd_t1_d");
        cyc(1'b1, 3'b111, "snd_t2_d");
        cyc(1'b1, 3'b100, "snd_t3_d");
        ack = 1'b1;
        cyc(1'b1, 3'b110, "to_and_ack");
        ack = 1'b0;

        // Fail-safe and ack ignored while off
        state = 2'b00;
        cyc(1'b0, 3'b000, "off_e");
        ack = 1'b1;
        cyc(1'b0, 3'b000, "ack_in_off");
        ack = 1'b0;
        cyc(1'b0, 3'b000, "off_e2");
        state = 2'b11;
        cyc(1'b0, 3'b111, "rsvd_entry");
        run_timeout("rsvd_timeout");
        state = 2'b00;
        cyc(1'b0, 3'b000, "off_f");
        state = 2'b10;
        cyc(1'b0, 3'b111, "snd_after_off_ack");
        cyc(1'b1, 3'b100, "snd_t1_f");

        // Reset mid-alarm, then re-evaluate
        rst = 1'b1;
        cyc(1'b0, 3'b000, "rst_mid");
        rst = 1'b0;
        cyc(1'b0, 3'b111, "rst_reeval");
        run_timeout("timeout_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
